// File: rtl/clk_sel_pkg.sv
// ============================================================================
//  Module : clk_sel_pkg
//  Brief  : Shared types, constants and one-hot helper for the clock-select
//           sequencer.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clk_sel_pkg;

    localparam int SETTLE_W   = 8;
    localparam int MAX_CLOCKS = 256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_ENABLE = 2'd2
    } state_t;

    // Callers size-cast the result down to their own clock count.
    function automatic logic [MAX_CLOCKS-1:0] onehot_encode(input int unsigned idx);
        logic [MAX_CLOCKS-1:0] w_one;
        w_one = MAX_CLOCKS'(1);
        return w_one << idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/clk_sel_settle_timer.sv
// ============================================================================
//  Module : clk_sel_settle_timer
//  Brief  : Loadable down-counter with zero flag that times each settle phase.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_sel_settle_timer
    import clk_sel_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic [SETTLE_W-1:0] i_load_val,
    output logic                o_zero
);

    logic [SETTLE_W-1:0] r_count;

    // Stops at zero, so the counter can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - SETTLE_W'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/clk_sel_sequencer.sv
// ============================================================================
//  Module : clk_sel_sequencer
//  Brief  : Drain/enable sequencer driving a glitch-free clock mux select.
//           Define CLK_SEL_SWITCH_COUNT_EN to add a saturating switch counter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clk_sel_sequencer
    import clk_sel_pkg::*;
#(
    parameter int NUM_CLOCKS    = 4,
    parameter int SEL_W         = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1,
    parameter int SETTLE_CYCLES = 8,
    parameter int RESET_SEL     = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic [SEL_W-1:0]      req_sel,
    output logic                  req_ready,
    output logic [NUM_CLOCKS-1:0] clk_select,
    output logic [SEL_W-1:0]      cur_sel,
    output logic                  busy,
    output logic                  switch_done,
    output logic                  req_err
`ifdef CLK_SEL_SWITCH_COUNT_EN
    ,
    output logic [15:0]           switch_count
`endif
);

    localparam int unsigned           c_num_clocks   = NUM_CLOCKS;
    localparam logic [SEL_W-1:0]      c_reset_sel    = SEL_W'(RESET_SEL);
    localparam logic [NUM_CLOCKS-1:0] c_reset_onehot = NUM_CLOCKS'(onehot_encode(RESET_SEL));
    localparam logic [SETTLE_W-1:0]   c_settle_load  = SETTLE_W'(SETTLE_CYCLES - 1);

    state_t                  r_state;
    logic [SEL_W-1:0]        r_target;
    logic [SEL_W-1:0]        r_cur_sel;
    logic [NUM_CLOCKS-1:0]   r_clk_select;
    logic                    r_switch_done;
    logic                    r_req_err;

    logic                    w_idle;
    logic                    w_sel_bad;
    logic                    w_noop;
    logic                    w_start;
    logic                    w_zero;
    logic                    w_load;
    logic [NUM_CLOCKS-1:0]   w_target_onehot;

    assign w_idle          = (r_state == ST_IDLE);
    assign w_sel_bad       = (32'(req_sel) >= c_num_clocks);
    assign w_noop          = (req_sel == r_cur_sel);
    assign w_start         = req_valid && w_idle && !w_sel_bad && !w_noop;
    assign w_load          = w_start || ((r_state == ST_DRAIN) && w_zero);
    assign w_target_onehot = NUM_CLOCKS'(onehot_encode(32'(r_target)));

    clk_sel_settle_timer u_settle_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (c_settle_load),
        .o_zero     (w_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_target      <= c_reset_sel;
            r_cur_sel     <= c_reset_sel;
            r_clk_select  <= c_reset_onehot;
            r_switch_done <= 1'b0;
            r_req_err     <= 1'b0;
        end else begin
            r_switch_done <= 1'b0;
            r_req_err     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (w_sel_bad) begin
                            r_req_err <= 1'b1;
                        end else if (w_noop) begin
                            r_switch_done <= 1'b1;
                        end else begin
                            r_target     <= req_sel;
                            r_clk_select <= '0;
                            r_state      <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The mux has been fully gated for the whole drain phase.
                    if (w_zero) begin
                        r_cur_sel    <= r_target;
                        r_clk_select <= w_target_onehot;
                        r_state      <= ST_ENABLE;
                    end
                end
                ST_ENABLE: begin
                    if (w_zero) begin
                        r_switch_done <= 1'b1;
                        r_state       <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CLK_SEL_SWITCH_COUNT_EN
    logic [15:0] r_switch_count;

    // Counts completed real switches only; no-op completions come from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_switch_count <= '0;
        end else if ((r_state == ST_ENABLE) && w_zero && (r_switch_count != 16'hFFFF)) begin
            r_switch_count <= r_switch_count + 16'd1;
        end
    end

    assign switch_count = r_switch_count;
`endif

    assign req_ready   = w_idle;
    assign busy        = !w_idle;
    assign clk_select  = r_clk_select;
    assign cur_sel     = r_cur_sel;
    assign switch_done = r_switch_done;
    assign req_err     = r_req_err;

endmodule

`default_nettype wire

// File: tb/tb_clk_sel_sequencer.sv
// ============================================================================
//  Module : tb_clk_sel_sequencer
//  Brief  : Scoreboard bench for clk_sel_sequencer against a timeline model.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clk_sel_sequencer;

    localparam int S = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel   = 2'd0;
    logic       req_ready;
    logic [3:0] clk_select;
    logic [1:0] cur_sel;
    logic       busy;
    logic       switch_done;
    logic       req_err;

    logic       v3 = 1'b0;
    logic [1:0] s3 = 2'd0;
    logic       ready3;
    logic [2:0] clk_select3;
    logic [1:0] cur_sel3;
    logic       busy3;
    logic       done3;
    logic       err3;

`ifdef CLK_SEL_SWITCH_COUNT_EN
    logic [15:0] switch_count;
    logic [15:0] switch_count3;
`endif

    always #5 clk = ~clk;

    clk_sel_sequencer #(.NUM_CLOCKS(4), .SETTLE_CYCLES(S), .RESET_SEL(0)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_sel(req_sel),
        .req_ready(req_ready), .clk_select(clk_select), .cur_sel(cur_sel),
        .busy(busy), .switch_done(switch_done), .req_err(req_err)
`ifdef CLK_SEL_SWITCH_COUNT_EN
        , .switch_count(switch_count)
`endif
    );

    clk_sel_sequencer #(.NUM_CLOCKS(3), .SETTLE_CYCLES(S), .RESET_SEL(0)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_sel(s3),
        .req_ready(ready3), .clk_select(clk_select3), .cur_sel(cur_sel3),
        .busy(busy3), .switch_done(done3), .req_err(err3)
`ifdef CLK_SEL_SWITCH_COUNT_EN
        , .switch_count(switch_count3)
`endif
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Timeline model: the last accepted switch is described by its accept
    // cycle, its source and its target; everything else follows by arithmetic.
    bit         m_active = 1'b0;
    int         m_T      = 0;
    logic [1:0] m_old    = 2'd0;
    logic [1:0] m_tgt    = 2'd0;
    int         m_count  = 0;

    typedef struct {int kind; int at;} ev_t;   // kind 0 err, 1 no-op done, 2 switch done
    ev_t sb[$];

    function automatic logic [1:0] cur_at(input int c);
        if (m_active && c >= m_T + S + 1) return m_tgt;
        return m_old;
    endfunction

    function automatic bit idle_at(input int c);
        return !m_active || c <= m_T || c >= m_T + 2*S + 1;
    endfunction

    function automatic logic [3:0] sel_at(input int c);
        logic [3:0] one;
        one = 4'b0001;
        if (m_active && c >= m_T + 1 && c <= m_T + S) return 4'b0000;
        return one << cur_at(c);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_old    = 2'd0;
        m_tgt    = 2'd0;
        m_count  = 0;
        sb.delete();
    endtask

    task automatic step(input logic v, input logic [1:0] s);
        ev_t e;
        @(posedge clk);
        #1;
        req_valid = v;
        req_sel   = s;
        if (v && idle_at(cyc)) begin
            if (s == cur_at(cyc)) begin
                e.kind = 1; e.at = cyc + 1;
            end else begin
                m_old    = cur_at(cyc);
                m_tgt    = s;
                m_T      = cyc;
                m_active = 1'b1;
                e.kind = 2; e.at = cyc + 2*S + 1;
            end
            sb.push_back(e);
        end
    endtask

    bit mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_done;
            bit exp_err;
            exp_done = 1'b0;
            exp_err  = 1'b0;
            if (sb.size() > 0 && sb[0].at == cyc) begin
                if (sb[0].kind == 0) exp_err = 1'b1;
                else exp_done = 1'b1;
                if (sb[0].kind == 2 && m_count < 65535) m_count++;
                void'(sb.pop_front());
            end
            chk("clk_select", int'(clk_select), int'(sel_at(cyc)));
            chk("cur_sel",    int'(cur_sel),    int'(cur_at(cyc)));
            chk("busy",       int'(busy),       int'(!idle_at(cyc)));
            chk("req_ready",  int'(req_ready),  int'(idle_at(cyc)));
            chk("switch_done", int'(switch_done), int'(exp_done));
            chk("req_err",    int'(req_err),    int'(exp_err));
`ifdef CLK_SEL_SWITCH_COUNT_EN
            chk("switch_count", int'(switch_count), m_count);
`endif
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_clk_select", int'(clk_select), 1);
        chk("reset_cur_sel",    int'(cur_sel),    0);
        chk("reset_req_ready",  int'(req_ready),  1);
        mon_en = 1'b1;

        // No-op request to the already selected clock.
        step(1'b1, 2'd0);
        step(1'b0, 2'd0);
        step(1'b0, 2'd0);

        // Switch aborted by reset five cycles after acceptance.
        step(1'b1, 2'd3);
        repeat (4) step(1'b0, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req_valid = 1'b0;
        model_reset();
        #1;
        chk("abort_clk_select_immediate", int'(clk_select), 1);
        chk("abort_busy_immediate",       int'(busy),       0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full switch to clock 2.
        step(1'b1, 2'd2);
        repeat (2*S + 2) step(1'b0, 2'd0);

        // Valid held high with a wandering select during a switch.
        step(1'b1, 2'd1);
        repeat (2*S) step(1'b1, 2'($urandom_range(0, 3)));
        repeat (3) step(1'b0, 2'd0);

        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
        end
        repeat (2*S + 3) step(1'b0, 2'd0);
        chk("scoreboard_drained", sb.size(), 0);

        // Out-of-range select on the three-clock instance.
        @(posedge clk);
        #1;
        v3 = 1'b1;
        s3 = 2'd3;
        @(posedge clk);
        #1;
        v3 = 1'b0;
        s3 = 2'd0;
        chk("n3_req_err",     int'(err3),        1);
        chk("n3_clk_select",  int'(clk_select3), 1);
        chk("n3_cur_sel",     int'(cur_sel3),    0);
        chk("n3_busy",        int'(busy3),       0);
        chk("n3_switch_done", int'(done3),       0);
        chk("n3_req_ready",   int'(ready3),      1);
        @(posedge clk);
        #1;
        chk("n3_req_err_single", int'(err3),        0);
        chk("n3_clk_select_2",   int'(clk_select3), 1);

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
